mult_share_arbiter: RTL and testbench



---
 rtl/mult_arb_pkg.sv | 25 ++
 rtl/mult_shift_add_core.sv | 73 +++++++
 rtl/mult_share_arbiter.sv | 139 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the shared shift-add multiplier arbiter.
// Holds the arbiter/core state encodings, default sizes, and an index-width helper.
package mult_arb_pkg;

  localparam int DEF_L_WORD = 4;
  localparam int DEF_N_REQ  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_BUSY,
    S_DONE
  } arb_state_e;

  typedef enum logic {
    C_IDLE,
    C_RUN
  } core_state_e;

  // Width needed to index n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_shift_add_core.sv
// Sequential shift-add multiplier: L_word run cycles per nonzero operation.
// A zero operand flushes the accumulator and the core stays idle (result 0).
module mult_shift_add_core
  import mult_arb_pkg::*;
#(
  parameter int L_word = DEF_L_WORD
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [L_word-1:0]     word1,
  input  logic [L_word-1:0]     word2,
  output logic                  ready,
  output logic [2*L_word-1:0]   product
);

  localparam int CNT_W = idx_width(L_word);

  core_state_e           state_q, state_d;
  logic [2*L_word-1:0]   mcand_q, mcand_d;
  logic [L_word-1:0]     mplier_q, mplier_d;
  logic [2*L_word-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      C_IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = {{L_word{1'b0}}, word1};
          mplier_d = word2;
          cnt_d    = CNT_W'(L_word - 1);
          if ((word1 != '0) && (word2 != '0)) state_d = C_RUN;
        end
      end
      C_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= C_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready   = (state_q == C_IDLE);
  assign product = acc_q;

endmodule

// File: rtl/mult_share_arbiter.sv
// Arbitrates N_REQ requesters onto one shift-add multiplier core and tags results.
// Define MULT_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int L_word = DEF_L_WORD,
  parameter int N_REQ  = DEF_N_REQ,
  parameter int ID_W   = idx_width(N_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*L_word-1:0]   word1_bus,
  input  logic [N_REQ*L_word-1:0]   word2_bus,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic [2*L_word-1:0]       product
);

  arb_state_e            state_q, state_d;
  logic [ID_W-1:0]       w_q, w_d;
  logic [L_word-1:0]     op1_q, op1_d;
  logic [L_word-1:0]     op2_q, op2_d;
  logic [ID_W-1:0]       done_id_q, done_id_d;
  logic [2*L_word-1:0]   product_q, product_d;
  logic [ID_W-1:0]       win_id;
  logic                  core_start;
  logic                  core_ready;
  logic [2*L_word-1:0]   core_product;

`ifdef MULT_ARB_RR_EN
  logic [ID_W-1:0]       ptr_q, ptr_d;

  // Scan downward so the requester closest after the pointer is written last.
  always_comb begin
    win_id = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr_q) + 1 + k) % N_REQ;
      if (req[idx]) win_id = ID_W'(idx);
    end
  end
`else
  always_comb begin
    win_id = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) win_id = ID_W'(i);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    done_id_d  = done_id_q;
    product_d  = product_q;
    core_start = 1'b0;
    grant      = '0;
    done       = 1'b0;
    busy       = (state_q != S_IDLE);
`ifdef MULT_ARB_RR_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req != '0) begin
          w_d     = win_id;
          op1_d   = word1_bus[win_id*L_word +: L_word];
          op2_d   = word2_bus[win_id*L_word +: L_word];
          state_d = S_LOAD;
`ifdef MULT_ARB_RR_EN
          ptr_d   = win_id;
`endif
        end
      end
      S_LOAD: begin
        grant[w_q] = 1'b1;
        core_start = 1'b1;
        state_d    = S_BUSY;
      end
      S_BUSY: begin
        if (core_ready) begin
          product_d = core_product;
          done_id_d = w_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      done_id_q <= '0;
      product_q <= '0;
`ifdef MULT_ARB_RR_EN
      ptr_q     <= ID_W'(N_REQ - 1);
`endif
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      done_id_q <= done_id_d;
      product_q <= product_d;
`ifdef MULT_ARB_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign done_id = done_id_q;
  assign product = product_q;

  mult_shift_add_core #(
    .L_word (L_word)
  ) u_core (
    .clock   (clock),
    .reset   (reset),
    .start   (core_start),
    .word1   (op1_q),
    .word2   (op2_q),
    .ready   (core_ready),
    .product (core_product)
  );

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: the driver predicts grant and result
// from the arbitration rule and plain multiplication; a monitor checks each pulse.
module tb_mult_share_arbiter;
  import mult_arb_pkg::*;

  localparam int L   = DEF_L_WORD;
  localparam int N   = DEF_N_REQ;
  localparam int IDW = idx_width(N);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N*L-1:0]    w1_bus = '0;
  logic [N*L-1:0]    w2_bus = '0;
  logic [N-1:0]      grant;
  logic              busy;
  logic              done;
  logic [IDW-1:0]    done_id;
  logic [2*L-1:0]    product;

  mult_share_arbiter #(.L_word(L), .N_REQ(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .word1_bus (w1_bus),
    .word2_bus (w2_bus),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .product   (product)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int cyc; logic [N-1:0] onehot; } gexp_t;
  typedef struct { int cyc; int id; longint prod; } dexp_t;
  gexp_t gq[$];
  dexp_t dq[$];

  int total = 0;
  int bad = 0;
  int model_ptr = N - 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Winner by rule: fixed = lowest set index; round-robin = first set index after last grant.
  function automatic int pick(input logic [N-1:0] r);
`ifdef MULT_ARB_RR_EN
    for (int k = 0; k < N; k++) begin
      int i;
      i = (model_ptr + 1 + k) % N;
      if (r[i]) return i;
    end
`else
    for (int i = 0; i < N; i++) if (r[i]) return i;
`endif
    return 0;
  endfunction

  function automatic logic [N*L-1:0] lane(input int i, input int v);
    logic [N*L-1:0] b;
    b = '0;
    b[i*L +: L] = L'(v);
    return b;
  endfunction

  // Called at a negedge with the DUT idle; the following posedge is the request edge k.
  task automatic do_op(input logic [N-1:0] r, input logic [N*L-1:0] a_bus,
                       input logic [N*L-1:0] b_bus, input bit drop, input bit scramble);
    int w, k, c;
    longint a, b;
    bit seen;
    gexp_t g;
    dexp_t d;
    req = r;
    w1_bus = a_bus;
    w2_bus = b_bus;
    w = pick(r);
    a = longint'(a_bus[w*L +: L]);
    b = longint'(b_bus[w*L +: L]);
`ifdef MULT_ARB_RR_EN
    model_ptr = w;
`endif
    k = cyc + 1;
    c = (a == 0 || b == 0) ? 0 : L;
    g.cyc = k;
    g.onehot = '0;
    g.onehot[w] = 1'b1;
    gq.push_back(g);
    // done is high across edge k+3+C, i.e. sampled at the negedge after edge k+2+C
    d.cyc = k + 2 + c;
    d.id = w;
    d.prod = a * b;
    dq.push_back(d);
    @(negedge clock);
    check("busy_at_grant", busy, 1);
    if (drop) req[w] = 1'b0;
    seen = 0;
    for (int t = 0; t < 4 * L + 10 && !seen; t++) begin
      @(negedge clock);
      if (done) seen = 1;
      else if (scramble) begin
        req = N'($urandom);
        w1_bus = (N*L)'($urandom);
        w2_bus = (N*L)'($urandom);
      end
    end
    check("done_seen", seen, 1);
    @(negedge clock);
    check("busy_after_done", busy, 0);
  endtask

  // Monitor: pops expectations whenever the DUT pulses grant or done.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (grant != '0 || done) check("grant_done_exclusive", (grant != '0) && done, 0);
        if (grant != '0) begin
          if (gq.size() == 0) check("unexpected_grant", grant, 0);
          else begin
            gexp_t g;
            g = gq.pop_front();
            check("grant_vec", grant, g.onehot);
            check("grant_cycle", cyc, g.cyc);
          end
        end
        if (done) begin
          if (dq.size() == 0) check("unexpected_done", done, 0);
          else begin
            dexp_t d;
            d = dq.pop_front();
            check("done_id", done_id, d.id);
            check("product", product, d.prod);
            check("done_cycle", cyc, d.cyc);
          end
        end
      end
    end
  end

  initial begin
    logic [N-1:0]   req_hold;
    logic [N*L-1:0] a_bus, b_bus;

    repeat (2) @(negedge clock);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_product", product, 0);
    reset = 1'b0;
    @(negedge clock);

    do_op(4'b0001, lane(0, 5), lane(0, 3), 1'b1, 1'b0);
    do_op(4'b0100, lane(2, 0), lane(2, 9), 1'b1, 1'b0);
    do_op(4'b1000, lane(3, 2**L - 1), lane(3, 2**L - 1), 1'b1, 1'b0);

    a_bus = '0;
    b_bus = '0;
    for (int i = 0; i < N; i++) begin
      a_bus[i*L +: L] = L'(i + 1);
      b_bus[i*L +: L] = L'(2**L - 1);
    end
`ifdef MULT_ARB_RR_EN
    for (int n = 0; n < 2 * N; n++) do_op('1, a_bus, b_bus, 1'b0, 1'b0);
`else
    req_hold = '1;
    for (int n = 0; n < N; n++) begin
      do_op(req_hold, a_bus, b_bus, 1'b1, 1'b0);
      req_hold = req;
    end
`endif

    // Reset while the core is running: outputs clear at once and no done follows.
    begin
      gexp_t g;
      int w;
      req = 4'b0010;
      w1_bus = lane(1, 2**L - 1);
      w2_bus = lane(1, 2**L - 1);
      w = pick(req);
      g.cyc = cyc + 1;
      g.onehot = '0;
      g.onehot[w] = 1'b1;
      gq.push_back(g);
      @(negedge clock);
      req = '0;
      repeat (2) @(negedge clock);
      check("busy_before_reset", busy, 1);
      reset = 1'b1;
      #1;
      check("midrst_grant", grant, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_done_id", done_id, 0);
      check("midrst_product", product, 0);
      gq.delete();
      dq.delete();
      model_ptr = N - 1;
      @(negedge clock);
      reset = 1'b0;
      repeat (L + 4) @(negedge clock);
    end
    do_op(4'b0010, lane(1, 7), lane(1, 6), 1'b1, 1'b0);

    for (int n = 0; n < 30; n++) begin
      logic [N-1:0] r;
      r = N'($urandom_range(1, 2**N - 1));
      a_bus = (N*L)'($urandom);
      b_bus = (N*L)'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) a_bus[i*L +: L] = '0;
        if ($urandom_range(0, 5) == 0) b_bus[i*L +: L] = '0;
      end
      do_op(r, a_bus, b_bus, bit'($urandom_range(0, 1)), 1'b1);
    end

    req = '0;
    repeat (5) @(negedge clock);
    check("grant_queue_empty", gq.size(), 0);
    check("done_queue_empty", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
